// File: rtl/countgen_period_meter.sv
`default_nettype none
// ============================================================================
// countgen_period_meter
//   Multi-channel synchronised, deglitched input period meter with stall detect.
//   Rev 1.0 - initial release
// ============================================================================
module countgen_period_meter #(
  parameter int CHANNELS = 4,
  parameter int CNT_W    = 32,
  parameter int FILT_W   = 8
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [CHANNELS-1:0]       in,
  input  logic [FILT_W-1:0]         filt_len,
  input  logic [CNT_W-1:0]          timeout,
  output logic [CHANNELS*CNT_W-1:0] period,
  output logic [CHANNELS-1:0]       valid,
  output logic [CHANNELS-1:0]       stalled
);

  typedef enum logic {
    ST_DISARMED = 1'b0,
    ST_ARMED    = 1'b1
  } state_t;

  localparam logic [FILT_W-1:0] RUN_MAX = '1;
  localparam logic [CNT_W-1:0]  CNT_MAX = '1;

  logic [FILT_W-1:0] filt_min;
  assign filt_min = (filt_len == '0) ? FILT_W'(1) : filt_len;

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    logic              sync1_q, sync1_d;
    logic              s_q, s_d;
    logic              f_q, f_d;
    logic              e_q, e_d;
    logic [FILT_W-1:0] run_q, run_d;
    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [CNT_W-1:0]  period_q, period_d;
    logic              valid_q, valid_d;
    logic              stalled_q, stalled_d;

    always_comb begin
      sync1_d = in[i];
      s_d     = sync1_q;

      // run_q counts how many cycles s_q has held its current value
      if (sync1_q != s_q) begin
        run_d = FILT_W'(1);
      end else if (run_q != RUN_MAX) begin
        run_d = run_q + FILT_W'(1);
      end else begin
        run_d = run_q;
      end

      f_d = f_q;
      if ((run_q >= filt_min) && (s_q != f_q)) begin
        f_d = s_q;
      end
      e_d = f_d & ~f_q;

      state_d   = state_q;
      cnt_d     = cnt_q;
      period_d  = period_q;
      valid_d   = 1'b0;
      stalled_d = stalled_q;
      case (state_q)
        ST_DISARMED: begin
          if (e_q) begin
            state_d   = ST_ARMED;
            cnt_d     = CNT_W'(1);
            stalled_d = 1'b0;
          end
        end
        ST_ARMED: begin
          // an edge in the timeout cycle still reports its measurement
          if (e_q) begin
            period_d = cnt_q;
            valid_d  = 1'b1;
            cnt_d    = CNT_W'(1);
          end else if ((timeout != '0) && (cnt_q >= timeout)) begin
            state_d   = ST_DISARMED;
            stalled_d = 1'b1;
          end else if (cnt_q != CNT_MAX) begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        default: state_d = ST_DISARMED;
      endcase
    end

    always_ff @(posedge clk) begin
      if (!rst_n) begin
        sync1_q   <= 1'b0;
        s_q       <= 1'b0;
        f_q       <= 1'b0;
        e_q       <= 1'b0;
        run_q     <= '0;
        state_q   <= ST_DISARMED;
        cnt_q     <= '0;
        period_q  <= '0;
        valid_q   <= 1'b0;
        stalled_q <= 1'b0;
      end else begin
        sync1_q   <= sync1_d;
        s_q       <= s_d;
        f_q       <= f_d;
        e_q       <= e_d;
        run_q     <= run_d;
        state_q   <= state_d;
        cnt_q     <= cnt_d;
        period_q  <= period_d;
        valid_q   <= valid_d;
        stalled_q <= stalled_d;
      end
    end

    assign period[i*CNT_W +: CNT_W] = period_q;
    assign valid[i]                 = valid_q;
    assign stalled[i]               = stalled_q;
  end

endmodule
`default_nettype wire
